// File: rtl/spi_xfer_arbiter.sv
// -----------------------------------------------------------------------------
// spi_xfer_arbiter
//
// Two-requester arbiter in front of a single-byte SPI master (mode 0,
// MSB first). A granted request is latched in full (data, slave-select
// mask, requester id, divider), so the requester may change its inputs
// right after the handshake. The byte is shifted out on mosi_pad_o while
// miso_pad_i is shifted in. A one-cycle response pulse reports the
// received byte and the id of the requester that was served.
//
// Transfer timeline (D = latched divider + 1 clocks):
//   SETUP : D clocks, slave selected, sclk low, MSB already on mosi
//   SHIFT : 16 half-periods of D clocks (8 rising, 8 falling), ends low
//   HOLD  : D clocks, slave still selected
//   then  : deselect, rsp_valid_o pulse, back to IDLE
//
// Configuration macro:
//   SPI_XFER_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins and
//                                no last-grant pointer exists; otherwise
//                                contention is resolved round-robin.
//
// Ports:
//   wb_clk_i      in   1  clock, rising edge
//   wb_rst_i      in   1  asynchronous reset, active low
//   req_valid_i   in   2  transfer request per requester
//   req_ready_o   out  2  accept per requester (only in IDLE)
//   req0_data_i   in   8  transmit byte, requester 0
//   req1_data_i   in   8  transmit byte, requester 1
//   req0_ss_i     in   8  slave select mask, requester 0 (1 = select)
//   req1_ss_i     in   8  slave select mask, requester 1 (1 = select)
//   divider_i     in   8  sclk half-period = divider_i + 1 clocks
//   rsp_valid_o   out  1  one-cycle completion pulse
//   rsp_id_o      out  1  requester served by the completed transfer
//   rsp_data_o    out  8  received byte (held until the next pulse)
//   busy_o        out  1  high whenever a transfer is in progress
//   sclk_pad_o    out  1  SPI clock
//   mosi_pad_o    out  1  SPI master-out
//   miso_pad_i    in   1  SPI master-in
//   ss_pad_o      out  8  slave selects, active low
// -----------------------------------------------------------------------------
module spi_xfer_arbiter (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_o,
  input  logic [7:0] req0_data_i,
  input  logic [7:0] req1_data_i,
  input  logic [7:0] req0_ss_i,
  input  logic [7:0] req1_ss_i,
  input  logic [7:0] divider_i,
  output logic       rsp_valid_o,
  output logic       rsp_id_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       sclk_pad_o,
  output logic       mosi_pad_o,
  input  logic       miso_pad_i,
  output logic [7:0] ss_pad_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0] r_state;
  logic [6:0] r_tx;        // bits still to be sent after the one on mosi
  logic [7:0] r_rx;
  logic       r_id;
  logic [7:0] r_div;
  logic [7:0] r_cnt;       // clocks elapsed in the current half-period
  logic [3:0] r_half;      // half-period index inside SHIFT
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_ss_pad;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [7:0] r_rsp_data;
`ifndef SPI_XFER_ARB_FIXED_PRIO_EN
  logic       r_last;      // requester granted most recently
`endif

  logic       w_grant_id;
  logic       w_grant_any;
  logic       w_idle_open;
  logic       w_accept;
  logic       w_tick;
  logic [7:0] w_sel_data;
  logic [7:0] w_sel_ss;

  // Arbitration: pick the requester that would win this cycle.
  always_comb begin
    w_grant_id  = 1'b0;
    w_grant_any = |req_valid_i;
`ifdef SPI_XFER_ARB_FIXED_PRIO_EN
    w_grant_id = ~req_valid_i[0];
`else
    case (req_valid_i)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last;
      default: w_grant_id = 1'b0;
    endcase
`endif
  end

  // Handshake: ready only in IDLE, never in the response cycle (this
  // guarantees one idle clock between transfers) and never during reset.
  always_comb begin
    req_ready_o = 2'b00;
    w_idle_open = (r_state == ST_IDLE) & ~r_rsp_valid & wb_rst_i;
    if (w_idle_open && w_grant_any) begin
      req_ready_o = w_grant_id ? 2'b10 : 2'b01;
    end else begin
      req_ready_o = 2'b00;
    end
    w_accept   = |(req_valid_i & req_ready_o);
    w_tick     = (r_cnt == r_div);
    w_sel_data = w_grant_id ? req1_data_i : req0_data_i;
    w_sel_ss   = w_grant_id ? req1_ss_i   : req0_ss_i;
  end

  // Transfer FSM, shift registers and registered pad/response outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_tx        <= 7'd0;
      r_rx        <= 8'd0;
      r_id        <= 1'b0;
      r_div       <= 8'd0;
      r_cnt       <= 8'd0;
      r_half      <= 4'd0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss_pad    <= 8'hFF;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 8'd0;
`ifndef SPI_XFER_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_SETUP;
            r_id     <= w_grant_id;
            r_tx     <= w_sel_data[6:0];
            r_mosi   <= w_sel_data[7];
            r_ss_pad <= ~w_sel_ss;
            r_div    <= divider_i;
            r_cnt    <= 8'd0;
            r_sclk   <= 1'b0;
`ifndef SPI_XFER_ARB_FIXED_PRIO_EN
            r_last   <= w_grant_id;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            // first rising edge: sample the slave's MSB
            r_state <= ST_SHIFT;
            r_cnt   <= 8'd0;
            r_half  <= 4'd0;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[6:0], miso_pad_i};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (!w_tick) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (r_half == 4'd15) begin
            // last half-period (sclk low) is over
            r_state <= ST_HOLD;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt  <= 8'd0;
            r_half <= r_half + 4'd1;
            r_sclk <= ~r_sclk;
            if (!r_half[0]) begin
              // falling edge; the 8th one leaves mosi on the LSB
              if (r_half != 4'd14) begin
                r_mosi <= r_tx[6];
                r_tx   <= {r_tx[5:0], 1'b0};
              end else begin
                r_mosi <= r_mosi;
              end
            end else begin
              r_rx <= {r_rx[6:0], miso_pad_i};
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state     <= ST_IDLE;
            r_ss_pad    <= 8'hFF;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= r_rx;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign sclk_pad_o  = r_sclk;
  assign mosi_pad_o  = r_mosi;
  assign ss_pad_o    = r_ss_pad;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [7:0] req0_data_i, req1_data_i, req0_ss_i, req1_ss_i, divider_i;
  logic       rsp_valid_o, rsp_id_o, busy_o, sclk_pad_o, mosi_pad_o, miso_pad_i;
  logic [7:0] rsp_data_o, ss_pad_o;

  spi_xfer_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_data_i(req0_data_i), .req1_data_i(req1_data_i),
    .req0_ss_i(req0_ss_i), .req1_ss_i(req1_ss_i), .divider_i(divider_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o), .sclk_pad_o(sclk_pad_o), .mosi_pad_o(mosi_pad_o),
    .miso_pad_i(miso_pad_i), .ss_pad_o(ss_pad_o)
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic [7:0] tx;
    logic [7:0] ss;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // slave model and bus monitor state
  logic [7:0] sl_byte  = 8'h00;
  logic [7:0] sl_shift = 8'h00;
  logic       sclk_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic [7:0] mon_mosi = 8'h00;
  int         mon_rise = 0;
  int         mon_edges = 0;
  int         ss_bad = 0;

  assign miso_pad_i = sl_shift[7];

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + mode-0 slave: sample away from the active edge.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (busy_o && !busy_prev) begin
      mon_mosi  = 8'h00;
      mon_rise  = 0;
      mon_edges = 0;
      ss_bad    = 0;
      sl_shift  = sl_byte;
    end else if (!sclk_prev && sclk_pad_o) begin
      mon_rise++;
      mon_edges++;
      mon_mosi = {mon_mosi[6:0], mosi_pad_o};
    end else if (sclk_prev && !sclk_pad_o) begin
      mon_edges++;
      sl_shift = {sl_shift[6:0], 1'b0};
    end
    if (busy_o && q.size() > 0 && ss_pad_o !== q[0].ss) ss_bad++;
    if (rsp_valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_id",      32'(rsp_id_o),    32'(e.id));
        chk("rsp_data",    32'(rsp_data_o),  32'(e.data));
        chk("rsp_cycle",   32'(cyc),         32'(e.cyc));
        chk("mosi_byte",   32'(mon_mosi),    32'(e.tx));
        chk("sclk_edges",  32'(mon_edges),   32'd16);
        chk("ss_during",   32'(ss_bad),      32'd0);
        chk("ss_after",    32'(ss_pad_o),    32'hFF);
        chk("ready_in_rsp", 32'(req_ready_o), 32'd0);
      end
    end
    sclk_prev = sclk_pad_o;
    busy_prev = busy_o;
  end

  task automatic xfer(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] dv,
                      input logic eid, input logic [7:0] slave, input int lat,
                      input bit push, input bit keep, input bit perturb);
    exp_t e;
    bit   got;
    got = 1'b0;
    req_valid_i = v; req0_data_i = d0; req1_data_i = d1;
    req0_ss_i = s0; req1_ss_i = s1; divider_i = dv; sl_byte = slave;
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((req_valid_i & req_ready_o) != 2'b00) begin
        got = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    chk("handshake", 32'(got), 32'd1);
    if (got) begin
      chk("grant", 32'(req_ready_o), eid ? 32'd2 : 32'd1);
      e.id   = eid;
      e.data = slave;
      e.tx   = eid ? d1 : d0;
      e.ss   = ~(eid ? s1 : s0);
      e.cyc  = cyc + lat;
      if (push) q.push_back(e);
      @(posedge wb_clk_i);
      #1;
      if (!keep) req_valid_i = 2'b00;
      if (perturb) begin
        req0_data_i = 8'h00;
        divider_i   = 8'h07;
      end
    end
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge wb_clk_i);
      #2;
      if (q.size() == 0) break;
    end
    chk("rsp_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

`ifdef SPI_XFER_ARB_FIXED_PRIO_EN
  logic [3:0] cont_ids = 4'b0000;
`else
  logic [3:0] cont_ids = 4'b1010;
`endif
  logic [7:0] cont_sl [4] = '{8'h5A, 8'hC3, 8'h96, 8'h0F};

  initial begin
    bit reached;
    wb_rst_i = 1'b0;
    req_valid_i = 2'b11;
    req0_data_i = 8'hFF; req1_data_i = 8'hFF;
    req0_ss_i = 8'hFF; req1_ss_i = 8'hFF; divider_i = 8'h00;

    // reset state, with both requests asserted
    #12;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_sclk",  32'(sclk_pad_o),  32'd0);
    chk("rst_mosi",  32'(mosi_pad_o),  32'd0);
    chk("rst_ss",    32'(ss_pad_o),    32'hFF);
    chk("rst_rspv",  32'(rsp_valid_o), 32'd0);
    chk("rst_rspid", 32'(rsp_id_o),    32'd0);
    chk("rst_rspd",  32'(rsp_data_o),  32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    @(negedge wb_clk_i);
    req_valid_i = 2'b00;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);

    // contention: both valid for four transfers, divider 0 -> +19
    for (int k = 0; k < 4; k++) begin
      xfer(2'b11, 8'h11, 8'h22, 8'h01, 8'h02, 8'd0, cont_ids[k], cont_sl[k], 19,
           1'b1, (k < 3), 1'b0);
      wait_done(200);
    end
    req_valid_i = 2'b00;

    // single transfer: A5 out, 3C in, mask 04, divider 1 -> +37
    xfer(2'b01, 8'hA5, 8'h00, 8'h04, 8'h00, 8'd1, 1'b0, 8'h3C, 37, 1'b1, 1'b0, 1'b0);
    wait_done(200);

    // divider 255 on requester 1 -> +4609
    xfer(2'b10, 8'h00, 8'hC7, 8'h00, 8'h80, 8'd255, 1'b1, 8'h81, 4609, 1'b1, 1'b0, 1'b0);
    wait_done(5000);

    // inputs change after accept: latched 5E / divider 2 -> +55
    xfer(2'b01, 8'h5E, 8'h00, 8'h10, 8'h00, 8'd2, 1'b0, 8'hE7, 55, 1'b1, 1'b0, 1'b1);
    wait_done(200);

    // null mask on requester 1
    xfer(2'b10, 8'h00, 8'hFF, 8'h00, 8'h00, 8'd0, 1'b1, 8'h24, 19, 1'b1, 1'b0, 1'b0);
    wait_done(200);

    // response fields hold after the pulse
    repeat (4) @(negedge wb_clk_i);
    chk("hold_data", 32'(rsp_data_o),  32'h24);
    chk("hold_id",   32'(rsp_id_o),    32'd1);
    chk("hold_rspv", 32'(rsp_valid_o), 32'd0);

    // reset after the 3rd sclk rising edge aborts the transfer
    xfer(2'b01, 8'h33, 8'h00, 8'h01, 8'h00, 8'd1, 1'b0, 8'h55, 37, 1'b0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk_i);
      #2;
      if (mon_rise >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rise3_reached", 32'(reached), 32'd1);
    wb_rst_i = 1'b0;
    #1;
    chk("mid_rst_ss",   32'(ss_pad_o),    32'hFF);
    chk("mid_rst_sclk", 32'(sclk_pad_o),  32'd0);
    chk("mid_rst_busy", 32'(busy_o),      32'd0);
    chk("mid_rst_rspv", 32'(rsp_valid_o), 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (60) @(negedge wb_clk_i);
    chk("no_rsp_after_abort", 32'(rsp_data_o), 32'd0);

    // after reset the pointer restarts: requester 0 wins, divider 3 -> +73
    xfer(2'b11, 8'h6C, 8'h99, 8'h02, 8'h08, 8'd3, 1'b0, 8'hB2, 73, 1'b1, 1'b0, 1'b0);
    wait_done(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 SHALL have port wb_clk_i, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port wb_rst_i, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port req_valid_i, input, 2, per-requester transfer request (bit i = requester i).
REQ-004 SHALL have port req_ready_o, output, 2, per-requester accept; transfer i accepted when req_valid_i[i] & req_ready_o[i].
REQ-005 SHALL have ports req0_data_i and req1_data_i, input, 8 each, transmit byte.
REQ-006 SHALL have ports req0_ss_i and req1_ss_i, input, 8 each, slave select mask (1 = select).
REQ-007 SHALL have port divider_i, input, 8, SCLK half-period = divider_i+1 clocks.
REQ-008 SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse with no backpressure.
REQ-009 SHALL have ports rsp_id_o (output, 1, winning requester) and rsp_data_o (output, 8, received byte).
REQ-010 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-011 SHALL have pad ports sclk_pad_o (out, 1), mosi_pad_o (out, 1), miso_pad_i (in, 1), ss_pad_o (out, 8, active-low).

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD.
REQ-013 IDLE: SHALL assert req_ready_o for exactly one granted requester only, and only while its req_valid_i is high; otherwise req_ready_o = 2'b00.
REQ-014 Arbitration SHALL be round-robin: when both requesters are valid, grant the requester not granted last; after reset the last-grant pointer = 1, so requester 0 wins first.
REQ-015 On acceptance the block SHALL latch data, ss mask, id and divider, then go to SETUP next cycle; inputs changing afterwards SHALL have no effect.
REQ-016 SETUP: ss_pad_o SHALL equal ~latched mask, mosi_pad_o SHALL equal bit 7, sclk_pad_o SHALL be 0, for divider+1 clocks.
REQ-017 SHIFT: sclk_pad_o SHALL toggle every divider+1 clocks, for 16 half-periods (8 rising edges, 8 falling edges), and SHALL end low.
REQ-018 SHIFT: miso_pad_i SHALL be sampled into the receive register LSB at each sclk rising edge; mosi_pad_o SHALL advance to the next lower bit at each falling edge except the 8th (MSB first, mode 0).
REQ-019 HOLD: ss_pad_o SHALL stay asserted for divider+1 clocks.
REQ-020 At HOLD exit: ss_pad_o SHALL go to 8'hFF, rsp_valid_o SHALL pulse for 1 cycle with rsp_id_o/rsp_data_o, and the FSM SHALL return to IDLE.
REQ-021 rsp_valid_o SHALL occur exactly 18*(divider+1)+1 clocks after the acceptance cycle.
REQ-022 IDLE SHALL last at least 1 clock between transfers, so no grant in the rsp_valid_o cycle.
REQ-023 rsp_id_o/rsp_data_o SHALL hold their values until the next rsp_valid_o.
REQ-024 Mask 8'h00 SHALL still run the full transfer with ss_pad_o = 8'hFF throughout.
REQ-025 divider_i = 0 SHALL give a 1-clock half-period; 255 SHALL give 256 clocks, with no counter wrap error.

Reset
REQ-026 On wb_rst_i = 0, immediately and asynchronously: FSM = IDLE, sclk_pad_o = 0, mosi_pad_o = 0, ss_pad_o = 8'hFF, req_ready_o = 0, rsp_valid_o = 0, rsp_id_o = 0, rsp_data_o = 0, busy_o = 0, last-grant = 1.
REQ-027 Reset mid-transfer SHALL abort the transfer with no rsp_valid_o pulse; after release, the block SHALL serve requests normally.

Configuration
REQ-028 With macro SPI_XFER_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (requester 0 always wins) and the last-grant pointer SHALL be unused; without it, round-robin per REQ-014.

Verification
REQ-029 Single transfer: divider 1, req0 data 8'hA5, mask 8'h04, miso driven from slave byte 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; ss_pad_o = 8'hFB; rsp_data_o = 8'h3C, rsp_id_o = 0, rsp_valid_o 37 clocks after accept.
REQ-030 Contention: both valid continuously for 4 transfers -> grant order 0,1,0,1; with SPI_XFER_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 Divider extremes: divider 0 -> sclk period 2 clocks, rsp at +19; divider 255 -> period 512 clocks, rsp at +4609.
REQ-032 Mid-transfer reset: assert wb_rst_i low after the 3rd sclk rising edge -> ss_pad_o = 8'hFF and sclk_pad_o = 0 within the same cycle, no rsp_valid_o; the next request completes correctly.
REQ-033 Input stability: change req0_data_i and divider_i after accept -> transmitted byte and timing match the latched values.
REQ-034 Null mask: mask 8'h00, data 8'hFF -> 16 sclk edges occur, ss_pad_o stays 8'hFF, rsp_valid_o pulses.
